key_mode_ctrl: RTL and testbench

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

---
 rtl/key_mode_ctrl.sv | 140 ++++++++++++++
 tb/tb_key_mode_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// Per-key debounce FSM: emits a one-cycle press pulse once a low level has held DEB_CYCLES cycles.
// Latency: pulse DEB_CYCLES+3 edges after the key falls (2 sync + 1 entry); no backpressure.
module key_deb #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PCHK = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;
    localparam logic [1:0] RCHK = 2'd3;

    logic          sync1;
    logic          sync2;
    logic [1:0]    st;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            st    <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            case (st)
                IDLE: begin
                    if (!sync2) begin
                        st  <= PCHK;
                        cnt <= '0;
                    end
                end
                PCHK: begin
                    if (sync2) begin
                        st <= IDLE;
                    end else if (cnt == LAST) begin
                        st    <= DOWN;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DOWN: begin
                    if (sync2) begin
                        st  <= RCHK;
                        cnt <= '0;
                    end
                end
                RCHK: begin
                    // Any low sample during release qualification means the key is still held.
                    if (!sync2) begin
                        st <= DOWN;
                    end else if (cnt == LAST) begin
                        st <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// Two-key 50/60 Hz mode selector producing PWM period/duty configuration.
// Latency: config registers one edge after a press pulse; no backpressure.
module key_mode_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned DUTY_NUM   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key0,
    input  logic        key1,
    output logic        key0_press,
    output logic        key1_press,
    output logic [1:0]  mode,
    output logic        led0,
    output logic        led1,
    output logic [31:0] period,
    output logic [31:0] duty_thr,
    output logic        cfg_update
);
    localparam logic [31:0] PER50  = 32'(CLK_HZ / 50 - 1);
    localparam logic [31:0] DUTY50 = 32'((CLK_HZ / 50) * DUTY_NUM / 4);
    localparam logic [31:0] PER60  = 32'(CLK_HZ / 60 - 1);
    localparam logic [31:0] DUTY60 = 32'((CLK_HZ / 60) * DUTY_NUM / 4);

    logic [1:0] tgt;
    logic       sel;

    key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
        .clk   (clk),
        .rst   (rst),
        .key   (key0),
        .press (key0_press)
    );

    key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk   (clk),
        .rst   (rst),
        .key   (key1),
        .press (key1_press)
    );

    // Simultaneous presses are ambiguous and dropped; reselecting the active mode is a no-op.
    always_comb begin
        tgt = key0_press ? 2'b01 : 2'b10;
        sel = (key0_press ^ key1_press) && (tgt != mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= 2'b01;
            period     <= PER50;
            duty_thr   <= DUTY50;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= sel;
            if (sel) begin
                mode     <= tgt;
                period   <= tgt[1] ? PER60 : PER50;
                duty_thr <= tgt[1] ? DUTY60 : DUTY50;
            end
        end
    end

    assign led0 = mode[0];
    assign led1 = mode[1];
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with DEB_CYCLES=4: vector table plus corner-case sequences.
module tb_key_mode_ctrl;
    logic        clk;
    logic        rst;
    logic        key0;
    logic        key1;
    logic        key0_press;
    logic        key1_press;
    logic [1:0]  mode;
    logic        led0;
    logic        led1;
    logic [31:0] period;
    logic [31:0] duty_thr;
    logic        cfg_update;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       r;
        logic       k0;
        logic       k1;
        logic       p0;
        logic       p1;
        logic [1:0] m;
        logic       cfg;
    } vec_t;

    vec_t vecs[$];

    key_mode_ctrl #(
        .CLK_HZ     (50_000_000),
        .DEB_CYCLES (4),
        .DUTY_NUM   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key0       (key0),
        .key1       (key1),
        .key0_press (key0_press),
        .key1_press (key1_press),
        .mode       (mode),
        .led0       (led0),
        .led1       (led1),
        .period     (period),
        .duty_thr   (duty_thr),
        .cfg_update (cfg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] per_of(input logic [1:0] m);
        return (m == 2'b10) ? 32'd833_332 : 32'd999_999;
    endfunction

    function automatic logic [31:0] duty_of(input logic [1:0] m);
        return (m == 2'b10) ? 32'd624_999 : 32'd750_000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, k0, k1, p0, p1, input logic [1:0] m, input logic cfg);
        vec_t v;
        v.r = r; v.k0 = k0; v.k1 = k1; v.p0 = p0; v.p1 = p1; v.m = m; v.cfg = cfg;
        vecs.push_back(v);
    endtask

    // Hold raw key levels for n cycles; a qualifying press pulses on step 7, config moves on step 8.
    task automatic add_hold(input logic k0, k1, input int n, input logic [1:0] mb, ma,
                            input logic ep0, ep1);
        for (int i = 1; i <= n; i++)
            add(1'b0, k0, k1, ep0 && (i == 7), ep1 && (i == 7),
                (i >= 8) ? ma : mb, (i == 8) && (ma != mb));
    endtask

    task automatic chk_cfg(input string nm, input logic [1:0] m, input logic cfg);
        chk({nm, "_ctl"}, {59'd0, mode, cfg_update, led0, led1},
            {59'd0, m, cfg, m[0], m[1]});
        chk({nm, "_cfg"}, {period, duty_thr}, {per_of(m), duty_of(m)});
    endtask

    initial begin
        rst  = 1'b1;
        key0 = 1'b1;
        key1 = 1'b1;

        add(1, 1, 1, 0, 0, 2'b01, 0);
        add(1, 1, 1, 0, 0, 2'b01, 0);
        add_hold(1, 1, 3,  2'b01, 2'b01, 0, 0);
        add_hold(1, 0, 20, 2'b01, 2'b10, 0, 1);
        add_hold(1, 1, 12, 2'b10, 2'b10, 0, 0);
        add_hold(1, 0, 10, 2'b10, 2'b10, 0, 1);
        add_hold(1, 1, 12, 2'b10, 2'b10, 0, 0);
        add_hold(0, 1, 10, 2'b10, 2'b01, 1, 0);
        add_hold(1, 1, 12, 2'b01, 2'b01, 0, 0);
        add_hold(0, 1, 10, 2'b01, 2'b01, 1, 0);
        add_hold(1, 1, 12, 2'b01, 2'b01, 0, 0);

        foreach (vecs[i]) begin
            rst  = vecs[i].r;
            key0 = vecs[i].k0;
            key1 = vecs[i].k1;
            tick();
            chk($sformatf("vec%0d_press", i), {62'd0, key0_press, key1_press},
                {62'd0, vecs[i].p0, vecs[i].p1});
            chk_cfg($sformatf("vec%0d", i), vecs[i].m, vecs[i].cfg);
        end

        // Switch to 60 Hz so a stray key0 pulse during bounce would be visible in mode.
        key1 = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        key1 = 1'b1;
        for (int i = 1; i <= 12; i++) tick();
        chk_cfg("pre_bounce", 2'b10, 1'b0);

        for (int c = 0; c < 40; c++) begin
            key0 = ((c / 2) % 2) != 0;
            tick();
            chk($sformatf("bounce%0d_p0", c), {63'd0, key0_press}, 64'd0);
        end
        key0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("bounce_rel%0d_p0", i), {63'd0, key0_press}, 64'd0);
        end
        chk_cfg("post_bounce", 2'b10, 1'b0);

        // Both keys fall together: pulses coincide but the selection is dropped.
        key0 = 1'b0;
        key1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("both%0d_press", i), {62'd0, key0_press, key1_press},
                (i == 7) ? 64'd3 : 64'd0);
            chk_cfg($sformatf("both%0d", i), 2'b10, 1'b0);
        end
        key0 = 1'b1;
        key1 = 1'b1;
        for (int i = 1; i <= 12; i++) tick();

        // Reset lands mid-qualification; the held key re-qualifies from scratch afterwards.
        key1 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("rst%0d_p1", i), {63'd0, key1_press}, 64'd0);
            chk_cfg($sformatf("rst%0d", i), 2'b01, 1'b0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("rel%0d_p1", i), {63'd0, key1_press}, (i == 7) ? 64'd1 : 64'd0);
            chk_cfg($sformatf("rel%0d", i), (i >= 8) ? 2'b10 : 2'b01, i == 8);
        end
        key1 = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
